sine_fold_pipe: RTL and testbench

- Pipelined quarter-wave sine/cosine generator stage for the FM synthesizer operator path.
- Accepts a phase word plus a per-sample phase-modulation offset and an optional cosine select.
- Folds the phase into a quarter-wave ROM address and drives an external synchronous ROM.
- Applies the quadrant sign to the returned magnitude and emits a signed sample with a fixed 3-cycle latency; a channel tag travels with each sample for time-multiplexed voices.

---
 rtl/sine_fold_pipe_if.sv | 35 +++
 rtl/sine_fold_pipe.sv | 91 +++++++++
 tb/tb_sine_fold_pipe.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sine_fold_pipe_if.sv
// rtl/sine_fold_pipe_if.sv - sample, ROM and output bus of the quarter-wave sine stage
// Signals:
//   in_valid/phase_in/phase_mod/cos_sel/ch_in : phase sample into the stage
//   rom_addr/rom_en                           : registered read request to external ROM
//   rom_data                                  : ROM magnitude, valid the cycle after the request
//   out_valid/sample_out/ch_out               : signed sample and its channel tag
// Modports: master = sample source and ROM, slave = sine_fold_pipe.
interface sine_fold_pipe_if #(
  parameter int PHASE_BITS = 32,
  parameter int ADDR_BITS  = 12,
  parameter int DATA_BITS  = 36,
  parameter int CH_BITS    = 4
);
  logic                  in_valid;
  logic [PHASE_BITS-1:0] phase_in;
  logic [PHASE_BITS-1:0] phase_mod;
  logic                  cos_sel;
  logic [CH_BITS-1:0]    ch_in;
  logic [ADDR_BITS-1:0]  rom_addr;
  logic                  rom_en;
  logic [DATA_BITS-2:0]  rom_data;
  logic                  out_valid;
  logic [DATA_BITS-1:0]  sample_out;
  logic [CH_BITS-1:0]    ch_out;

  modport master (
    output in_valid, phase_in, phase_mod, cos_sel, ch_in, rom_data,
    input  rom_addr, rom_en, out_valid, sample_out, ch_out
  );

  modport slave (
    input  in_valid, phase_in, phase_mod, cos_sel, ch_in, rom_data,
    output rom_addr, rom_en, out_valid, sample_out, ch_out
  );
endinterface

// File: rtl/sine_fold_pipe.sv
// rtl/sine_fold_pipe.sv - pipelined quarter-wave sine/cosine fold with 3-cycle latency
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : sine_fold_pipe_if.slave (phase sample in, ROM request/response, signed sample out)
module sine_fold_pipe #(
  parameter int PHASE_BITS = 32,
  parameter int ADDR_BITS  = 12,
  parameter int DEPTH      = 4096,
  parameter int DATA_BITS  = 36,
  parameter int CH_BITS    = 4
) (
  input logic             clk,
  input logic             rst,
  sine_fold_pipe_if.slave bus
);

  localparam logic [PHASE_BITS-1:0] QUARTER  = {2'b01, {(PHASE_BITS-2){1'b0}}};
  localparam logic [ADDR_BITS-1:0]  ADDR_MAX = ADDR_BITS'(DEPTH - 1);
  localparam int                    SHIFT    = PHASE_BITS - ADDR_BITS - 2;

  // Stage 0: phase sum and quadrant fold
  logic [PHASE_BITS-1:0] p;
  logic [ADDR_BITS+1:0]  t;
  logic [1:0]            quad;
  logic [ADDR_BITS-1:0]  idx;
  logic [ADDR_BITS-1:0]  fold_addr;

  always_comb begin
    p         = bus.phase_in + bus.phase_mod + (bus.cos_sel ? QUARTER : '0);
    // Truncating shift keeps the top ADDR_BITS+2 bits; no rounding of the discarded LSBs.
    t         = (ADDR_BITS+2)'(p >> SHIFT);
    quad      = t[ADDR_BITS+1:ADDR_BITS];
    idx       = t[ADDR_BITS-1:0];
    // Odd quadrants run the table backwards so one quarter wave covers the full cycle.
    fold_addr = quad[0] ? (ADDR_MAX - idx) : idx;
  end

  logic [ADDR_BITS-1:0] rom_addr_q;
  logic                 rom_en_q;
  logic                 v1, v2;
  logic                 neg1, neg2;
  logic [CH_BITS-1:0]   ch1, ch2;
  logic                 out_valid_q;
  logic [DATA_BITS-1:0] sample_q;
  logic [CH_BITS-1:0]   ch_out_q;
  logic [DATA_BITS-1:0] mag_ext;

  // Zero-extending before negation means -(2**(DATA_BITS-1)-1) is the most negative result.
  assign mag_ext = {1'b0, bus.rom_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q  <= '0;
      rom_en_q    <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      neg1        <= 1'b0;
      neg2        <= 1'b0;
      ch1         <= '0;
      ch2         <= '0;
      out_valid_q <= 1'b0;
      sample_q    <= '0;
      ch_out_q    <= '0;
    end else begin
      rom_en_q <= bus.in_valid;
      v1       <= bus.in_valid;
      if (bus.in_valid) begin
        rom_addr_q <= fold_addr;
        neg1       <= quad[1];
        ch1        <= bus.ch_in;
      end
      v2   <= v1;
      neg2 <= neg1;
      ch2  <= ch1;
      // rom_data for the sample in stage 2 is on the bus this cycle.
      out_valid_q <= v2;
      if (v2) begin
        sample_q <= neg2 ? -mag_ext : mag_ext;
        ch_out_q <= ch2;
      end
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.rom_en     = rom_en_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.sample_out = sample_q;
  assign bus.ch_out     = ch_out_q;

endmodule

// File: tb/tb_sine_fold_pipe.sv
// tb/tb_sine_fold_pipe.sv - directed vector bench for sine_fold_pipe with a registered ROM model
module tb_sine_fold_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sine_fold_pipe_if #(.PHASE_BITS(32), .ADDR_BITS(12), .DATA_BITS(36), .CH_BITS(4)) bus ();

  sine_fold_pipe #(
    .PHASE_BITS(32), .ADDR_BITS(12), .DEPTH(4096), .DATA_BITS(36), .CH_BITS(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ROM model: data = address, unless forced to a fixed magnitude.
  logic        rom_force = 1'b0;
  logic [34:0] rom_force_val = '0;
  logic [34:0] rom_q = '0;

  always @(posedge clk) begin
    if (bus.rom_en) rom_q <= rom_force ? rom_force_val : 35'(bus.rom_addr);
  end
  assign bus.rom_data = rom_q;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ph, input logic [31:0] md,
                       input logic cs, input logic [3:0] ch);
    bus.in_valid  = v;
    bus.phase_in  = ph;
    bus.phase_mod = md;
    bus.cos_sel   = cs;
    bus.ch_in     = ch;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] ph;
    logic [31:0] md;
    logic        cs;
    logic [3:0]  ch;
    logic [11:0] addr;
    logic [35:0] smp;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  initial begin
    // quadrant fold, back to back
    vecs[0]  = '{1'b1, 32'h0010_0000, 32'h0,         1'b0, 4'd1,  12'd4,    36'h0_0000_0004};
    vecs[1]  = '{1'b1, 32'h4010_0000, 32'h0,         1'b0, 4'd2,  12'd4091, 36'h0_0000_0FFB};
    vecs[2]  = '{1'b1, 32'h8010_0000, 32'h0,         1'b0, 4'd3,  12'd4,    36'hF_FFFF_FFFC};
    vecs[3]  = '{1'b1, 32'hC010_0000, 32'h0,         1'b0, 4'd4,  12'd4091, 36'hF_FFFF_F005};
    // cosine select and modulation
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'h0,         1'b1, 4'd5,  12'd4095, 36'h0_0000_0FFF};
    vecs[5]  = '{1'b1, 32'h0000_0000, 32'hFFFC_0000, 1'b0, 4'd6,  12'd0,    36'h0_0000_0000};
    vecs[6]  = '{1'b1, 32'h0000_0000, 32'hFFF0_0000, 1'b0, 4'd7,  12'd3,    36'hF_FFFF_FFFD};
    vecs[7]  = '{1'b1, 32'hF000_0000, 32'h2010_0000, 1'b0, 4'd8,  12'd1028, 36'h0_0000_0404};
    vecs[8]  = '{1'b1, 32'h7FFC_0000, 32'h0,         1'b0, 4'd9,  12'd0,    36'h0_0000_0000};
    vecs[9]  = '{1'b1, 32'h8000_0000, 32'h0,         1'b0, 4'd10, 12'd0,    36'h0_0000_0000};
    vecs[10] = '{1'b1, 32'h4010_0000, 32'h0,         1'b1, 4'd11, 12'd4,    36'hF_FFFF_FFFC};
    // bubbles 1,0,1,1,0,1 with ch 1..6; addr holds across bubbles
    vecs[11] = '{1'b1, 32'h0020_0000, 32'h0,         1'b0, 4'd1,  12'd8,    36'h0_0000_0008};
    vecs[12] = '{1'b0, 32'h1234_5678, 32'h0,         1'b0, 4'd2,  12'd8,    36'h0};
    vecs[13] = '{1'b1, 32'h4020_0000, 32'h0,         1'b0, 4'd3,  12'd4087, 36'h0_0000_0FF7};
    vecs[14] = '{1'b1, 32'h8030_0000, 32'h0,         1'b0, 4'd4,  12'd12,   36'hF_FFFF_FFF4};
    vecs[15] = '{1'b0, 32'hFFFF_FFFF, 32'h0,         1'b1, 4'd5,  12'd12,   36'h0};
    vecs[16] = '{1'b1, 32'hC000_0000, 32'h0,         1'b0, 4'd6,  12'd4095, 36'hF_FFFF_F001};

    // reset held 3 cycles with in_valid high
    rst = 1'b1;
    drive(1'b1, 32'h4010_0000, 32'h0, 1'b0, 4'd9);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_sample", 64'(bus.sample_out), 64'd0);
      check("rst_rom_en", 64'(bus.rom_en), 64'd0);
      check("rst_rom_addr", 64'(bus.rom_addr), 64'd0);
    end
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("post_rst_rom_en", 64'(bus.rom_en), 64'd0);
    end

    // table: vector c is sampled at edge c, its output appears after edge c+2
    for (int c = 0; c < NV + 2; c++) begin
      if (c < NV) drive(vecs[c].v, vecs[c].ph, vecs[c].md, vecs[c].cs, vecs[c].ch);
      else        drive(1'b0, 32'h0, 32'h0, 1'b0, 4'd0);
      step();
      if (c < NV) begin
        check($sformatf("rom_en[%0d]", c), 64'(bus.rom_en), 64'(vecs[c].v));
        check($sformatf("rom_addr[%0d]", c), 64'(bus.rom_addr), 64'(vecs[c].addr));
      end else begin
        check("rom_en_idle", 64'(bus.rom_en), 64'd0);
      end
      if (c >= 2) begin
        check($sformatf("out_valid[%0d]", c - 2), 64'(bus.out_valid), 64'(vecs[c-2].v));
        if (vecs[c-2].v) begin
          check($sformatf("sample[%0d]", c - 2), 64'(bus.sample_out), 64'(vecs[c-2].smp));
          check($sformatf("ch_out[%0d]", c - 2), 64'(bus.ch_out), 64'(vecs[c-2].ch));
        end
      end
    end
    step();
    check("drain_out_valid", 64'(bus.out_valid), 64'd0);

    // extreme magnitude in quadrant 3
    rom_force     = 1'b1;
    rom_force_val = 35'h7_FFFF_FFFF;
    drive(1'b1, 32'hC000_0000, 32'h0, 1'b0, 4'd9);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 4'd0);
    step();
    check("ext_early_valid", 64'(bus.out_valid), 64'd0);
    step();
    check("ext_out_valid", 64'(bus.out_valid), 64'd1);
    check("ext_sample", 64'(bus.sample_out), 64'h0_0000_0008_0000_0001);
    check("ext_sign", 64'(bus.sample_out[35]), 64'd1);
    check("ext_ch", 64'(bus.ch_out), 64'd9);
    step();
    check("ext_after_valid", 64'(bus.out_valid), 64'd0);
    check("ext_hold_sample", 64'(bus.sample_out), 64'h0_0000_0008_0000_0001);
    rom_force = 1'b0;

    // reset with two samples in flight; rst beats in_valid
    drive(1'b1, 32'h0010_0000, 32'h0, 1'b0, 4'd1);
    step();
    drive(1'b1, 32'h4010_0000, 32'h0, 1'b0, 4'd2);
    step();
    rst = 1'b1;
    drive(1'b1, 32'h8010_0000, 32'h0, 1'b0, 4'd3);
    step();
    check("mid_rst_rom_en", 64'(bus.rom_en), 64'd0);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_rst_flushed", 64'(bus.out_valid), 64'd0);
    end
    drive(1'b1, 32'h8010_0000, 32'h0, 1'b0, 4'd7);
    step();
    check("post_mid_rom_en", 64'(bus.rom_en), 64'd1);
    check("post_mid_rom_addr", 64'(bus.rom_addr), 64'd4);
    check("post_mid_lat1", 64'(bus.out_valid), 64'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 4'd0);
    step();
    check("post_mid_lat2", 64'(bus.out_valid), 64'd0);
    step();
    check("post_mid_lat3", 64'(bus.out_valid), 64'd1);
    check("post_mid_sample", 64'(bus.sample_out), 64'h0_0000_000F_FFFF_FFFC);
    check("post_mid_ch", 64'(bus.ch_out), 64'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_bad);
    $finish;
  end

endmodule
